prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the CPU's program memory: accepts a framed byte stream on a valid/ready interface and writes it into the 16x8 program memory that the CPU fetches from.
- Holds the CPU in reset while loading. Checks a checksum, pads unused words, and releases the CPU only after a successful load.
- Sits between the host/UART byte source and the program memory write port. Drives the CPU's active-low reset input.

Parameters:
- ADDR_W, 4, program memory address width.
- DEPTH, 16, number of words (must equal 2**ADDR_W).
- FILL_BYTE, 8'hF0, value written to unused words (HLT opcode).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- i_data  input  8  stream byte.
- i_valid  input  1  i_data valid.
- o_ready  output  1  loader can accept a byte this cycle.
- o_we  output  1  memory write strobe, one cycle per word.
- o_waddr  output  ADDR_W  memory write address.
- o_wdata  output  8  memory write data.
- o_cpu_rst_n  output  1  active-low reset to CPU; high means run.
- o_busy  output  1  load in progress.
- o_done  output  1  one-cycle pulse on successful load.
- o_err  output  1  level, set on framing/checksum error.

Behaviour:

Reset values:
- All outputs 0, so the CPU is held in reset.
- State IDLE; internal len, idx and sum cleared.
- Reset mid-load aborts immediately; memory contents are left as-is.

Frame format: LEN byte, then LEN data bytes, then CSUM byte.
- Valid LEN is 1..DEPTH.
- CSUM = (LEN + sum of data bytes) mod 256, 8-bit wrap.

Handshake:
- A byte transfers on a rising edge where i_valid && o_ready.
- o_ready is registered and is 1 only in LEN, DATA and CSUM.
- The source may hold i_valid indefinitely. The loader never drops a byte it has transferred.

States:
- IDLE: o_ready=0, o_busy=0.
  - i_start -> LEN; o_cpu_rst_n<=0, o_busy<=1, o_err<=0, sum<=0, idx<=0.
- LEN: on transfer, sum<=byte, len<=byte.
  - byte==0 or byte>DEPTH -> ERR.
  - Otherwise -> DATA.
- DATA: on transfer, o_we<=1, o_waddr<=idx, o_wdata<=byte (registered, so the write appears the cycle after transfer); sum<=sum+byte; idx<=idx+1.
  - After the LEN-th byte -> CSUM.
  - Back-to-back transfers give back-to-back o_we cycles.
- CSUM: on transfer:
  - byte==sum -> FILL if len<DEPTH, else DONE.
  - Mismatch -> ERR.
- FILL: o_ready=0. One write per cycle of FILL_BYTE at addresses len..DEPTH-1, then -> DONE.
  - Takes exactly DEPTH-len cycles.
- DONE: o_done pulses 1 cycle on entry; o_cpu_rst_n<=1, o_busy<=0.
  - o_cpu_rst_n stays 1 until the next i_start or reset.
- ERR: o_err<=1 (held), o_busy<=0, o_cpu_rst_n stays 0.
  - Only i_start or i_rst exits.

Other rules:
- o_we is 0 in every cycle not listed above. At most one write per cycle.
- Address wrap: idx is ADDR_W bits plus a terminal-count compare against len. Index DEPTH is never written; LEN==DEPTH fills all 16 words and skips FILL.
- i_start while busy (LEN/DATA/CSUM/FILL) is ignored.
- i_start in DONE restarts the load and re-asserts CPU reset the next cycle.
- i_start and i_valid in the same IDLE cycle: the start is taken, the byte is not (o_ready was 0).

Test Plan:
1. Reset, i_start, stream 03 51 E0 F0 24 with i_valid held -> writes (0,51),(1,E0),(2,F0), then F0 to addresses 3..15 on 13 consecutive cycles; o_done pulses; o_cpu_rst_n rises; o_err=0.
2. LEN=10 (16), 16 data bytes 01..10, correct CSUM=98 -> 16 writes, no FILL cycles; o_done pulses immediately after CSUM.
3. Frame 02 AA BB 00 (wrong, correct is 67) -> no FILL; o_err=1, o_cpu_rst_n stays 0, o_done never pulses; a subsequent good frame clears o_err and completes.
4. LEN=00 and, separately, LEN=11 -> ERR right after the LEN transfer, zero writes.
5. Case 1 with i_valid toggled randomly and i_start pulsed mid-DATA -> identical write sequence, start ignored, one o_done.
6. Assert i_rst during DATA after 2 of 3 bytes -> all outputs 0 asynchronously; after release, state IDLE, o_ready=0, no further writes until i_start.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory loader: takes a LEN/DATA/CSUM framed byte stream, writes it into
// program memory, pads unused words and holds the CPU in reset until a good load.
module prog_loader #(
    parameter int          ADDR_W    = 4,
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  FILL_BYTE = 8'hF0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [7:0]        o_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // state | meaning
    // IDLE  | waiting for first start, CPU held in reset
    // LEN   | accepting length byte
    // DATA  | accepting and writing data bytes
    // CSUM  | accepting checksum byte
    // FILL  | padding words len..DEPTH-1 with FILL_BYTE
    // DONE  | load good, CPU running
    // ERR   | framing or checksum error, CPU held in reset
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE, S_ERR
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        DEPTH_B  = 8'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W:0]   len, len_n;
    logic [ADDR_W-1:0] idx, idx_n, waddr_n;
    logic [7:0]        sum, sum_n, wdata_n;
    logic              we_n, ready_n, cpu_rst_n_n, busy_n, done_n, err_n;
    logic              xfer;

    assign xfer = i_valid && o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            len         <= '0;
            idx         <= '0;
            sum         <= '0;
            o_ready     <= 1'b0;
            o_we        <= 1'b0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_cpu_rst_n <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            idx         <= idx_n;
            sum         <= sum_n;
            o_ready     <= ready_n;
            o_we        <= we_n;
            o_waddr     <= waddr_n;
            o_wdata     <= wdata_n;
            o_cpu_rst_n <= cpu_rst_n_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
            o_err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        len_n       = len;
        idx_n       = idx;
        sum_n       = sum;
        we_n        = 1'b0;
        waddr_n     = o_waddr;
        wdata_n     = o_wdata;
        cpu_rst_n_n = o_cpu_rst_n;
        busy_n      = o_busy;
        done_n      = 1'b0;
        err_n       = o_err;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_n     = S_LEN;
                    cpu_rst_n_n = 1'b0;
                    busy_n      = 1'b1;
                    err_n       = 1'b0;
                    sum_n       = '0;
                    idx_n       = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    sum_n = i_data;
                    len_n = i_data[ADDR_W:0];
                    if (i_data == 8'd0 || i_data > DEPTH_B) state_n = S_ERR;
                    else                                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_n    = 1'b1;
                    waddr_n = idx;
                    wdata_n = i_data;
                    sum_n   = sum + i_data;
                    idx_n   = idx + 1'b1;
                    // terminal count: idx wraps at DEPTH, so compare against len-1
                    if ({1'b0, idx} == len - 1'b1) state_n = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (i_data == sum) state_n = (len < DEPTH_L) ? S_FILL : S_DONE;
                    else               state_n = S_ERR;
                end
            end
            S_FILL: begin
                we_n    = 1'b1;
                waddr_n = idx;
                wdata_n = FILL_BYTE;
                idx_n   = idx + 1'b1;
                if (idx == LAST_IDX) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_DONE && state != S_DONE) begin
            done_n      = 1'b1;
            cpu_rst_n_n = 1'b1;
            busy_n      = 1'b0;
        end
        if (state_n == S_ERR && state != S_ERR) begin
            err_n  = 1'b1;
            busy_n = 1'b0;
        end
        ready_n = (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_CSUM);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good frames, full-depth frame, bad checksum,
// bad length, stalled source with stray start, and reset mid-load.
module tb_prog_loader;

    logic       i_clk, i_rst, i_start, i_valid;
    logic [7:0] i_data;
    logic       o_ready, o_we, o_cpu_rst_n, o_busy, o_done, o_err;
    logic [3:0] o_waddr;
    logic [7:0] o_wdata;

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic [3:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];

    prog_loader #(.ADDR_W(4), .DEPTH(16), .FILL_BYTE(8'hF0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .o_we(o_we), .o_waddr(o_waddr),
        .o_wdata(o_wdata), .o_cpu_rst_n(o_cpu_rst_n), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        cyc++;
        if (o_we === 1'b1) begin
            wa.push_back(o_waddr);
            wd.push_back(o_wdata);
            wc.push_back(cyc);
        end
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        i_data  = b;
        i_valid = 1'b1;
        while (o_ready !== 1'b1 && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 50) begin
            vecs++; errs++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic pulse_start;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        #1;
    endtask

    task automatic wait_idle;
        int t;
        t = 0;
        while (o_busy === 1'b1 && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        vecs++;
        if (t >= 100) begin
            errs++;
            $display("FAIL busy_timeout: o_busy still %b after %0d cycles", o_busy, t);
        end
        repeat (2) @(negedge i_clk);
        #1;
    endtask

    task automatic clear_log;
        wa.delete(); wd.delete(); wc.delete();
    endtask

    task automatic test_reset;
        logic [19:0] outs;
        repeat (2) @(negedge i_clk);
        #1;
        outs = {o_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_busy, o_done, o_err};
        vecs++;
        if (outs !== 20'h0) begin errs++; $display("FAIL reset_outputs: got %h expected 00000", outs); end
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        outs = {o_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_busy, o_done, o_err};
        vecs++;
        if (outs !== 20'h0) begin errs++; $display("FAIL idle_outputs: got %h expected 00000", outs); end
    endtask

    task automatic test_basic;
        int dc0;
        logic [7:0] exp_d;
        clear_log();
        dc0 = done_cnt;
        @(negedge i_clk);
        // start and a stray valid byte in the same IDLE cycle: byte must be ignored
        i_start = 1'b1; i_valid = 1'b1; i_data = 8'h00;
        @(negedge i_clk);
        i_start = 1'b0; i_valid = 1'b0;
        #1;
        vecs++;
        if ({o_ready, o_busy, o_cpu_rst_n} !== 3'b110) begin
            errs++; $display("FAIL basic_start: ready/busy/rst_n got %b expected 110", {o_ready, o_busy, o_cpu_rst_n});
        end
        send(8'h03); send(8'h51); send(8'hE0); send(8'hF0); send(8'h24);
        wait_idle();
        vecs++;
        if (wa.size() != 16) begin errs++; $display("FAIL basic_count: got %0d writes expected 16", wa.size()); end
        for (int i = 0; i < 16; i++) begin
            exp_d = (i == 0) ? 8'h51 : (i == 1) ? 8'hE0 : 8'hF0;
            vecs++;
            if (i >= wa.size() || wa[i] !== 4'(i) || wd[i] !== exp_d) begin
                errs++; $display("FAIL basic_write[%0d]: got %h/%h expected %h/%h", i,
                                 (i < wa.size()) ? wa[i] : 4'hx, (i < wd.size()) ? wd[i] : 8'hxx, 4'(i), exp_d);
            end
        end
        vecs++;
        if (wc.size() == 16 && (wc[15] - wc[3]) != 12) begin
            errs++; $display("FAIL basic_fill_span: got %0d cycles expected 12", wc[15] - wc[3]);
        end
        vecs++;
        if (done_cnt - dc0 != 1) begin errs++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - dc0); end
        vecs++;
        if ({o_cpu_rst_n, o_err, o_busy, o_done} !== 4'b1000) begin
            errs++; $display("FAIL basic_final: rst_n/err/busy/done got %b expected 1000", {o_cpu_rst_n, o_err, o_busy, o_done});
        end
    endtask

    task automatic test_full;
        int dc0;
        clear_log();
        dc0 = done_cnt;
        pulse_start();
        vecs++;
        if (o_cpu_rst_n !== 1'b0) begin errs++; $display("FAIL full_restart_rst: got %b expected 0", o_cpu_rst_n); end
        send(8'h10);
        for (int i = 1; i <= 16; i++) send(8'(i));
        send(8'h98);
        vecs++;
        if ({o_done, o_we} !== 2'b10) begin
            errs++; $display("FAIL full_done_now: done/we got %b expected 10", {o_done, o_we});
        end
        wait_idle();
        vecs++;
        if (wa.size() != 16) begin errs++; $display("FAIL full_count: got %0d writes expected 16", wa.size()); end
        for (int i = 0; i < 16; i++) begin
            vecs++;
            if (i >= wa.size() || wa[i] !== 4'(i) || wd[i] !== 8'(i + 1)) begin
                errs++; $display("FAIL full_write[%0d]: got %h/%h expected %h/%h", i,
                                 (i < wa.size()) ? wa[i] : 4'hx, (i < wd.size()) ? wd[i] : 8'hxx, 4'(i), 8'(i + 1));
            end
        end
        vecs++;
        if (done_cnt - dc0 != 1) begin errs++; $display("FAIL full_done: got %0d pulses expected 1", done_cnt - dc0); end
    endtask

    task automatic test_bad_csum;
        int dc0;
        clear_log();
        dc0 = done_cnt;
        pulse_start();
        send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
        vecs++;
        if ({o_err, o_busy, o_cpu_rst_n} !== 3'b100) begin
            errs++; $display("FAIL csum_err: err/busy/rst_n got %b expected 100", {o_err, o_busy, o_cpu_rst_n});
        end
        repeat (20) @(negedge i_clk);
        #1;
        vecs++;
        if (wa.size() != 2 || done_cnt != dc0 || o_err !== 1'b1) begin
            errs++; $display("FAIL csum_hold: writes %0d done %0d err %b expected 2 0 1", wa.size(), done_cnt - dc0, o_err);
        end
        clear_log();
        pulse_start();
        vecs++;
        if (o_err !== 1'b0) begin errs++; $display("FAIL csum_err_clear: got %b expected 0", o_err); end
        send(8'h01); send(8'h42); send(8'h43);
        wait_idle();
        vecs++;
        if (wa.size() != 16 || wd[0] !== 8'h42 || wd[15] !== 8'hF0 || wa[15] !== 4'hF) begin
            errs++; $display("FAIL csum_recover_writes: got %0d writes expected 16 (42 ... F0@F)", wa.size());
        end
        vecs++;
        if (done_cnt - dc0 != 1 || {o_err, o_cpu_rst_n} !== 2'b01) begin
            errs++; $display("FAIL csum_recover: done %0d err/rst_n %b expected 1 01", done_cnt - dc0, {o_err, o_cpu_rst_n});
        end
    endtask

    task automatic test_bad_len;
        logic [7:0] lens [2];
        lens[0] = 8'h00;
        lens[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            clear_log();
            pulse_start();
            send(lens[k]);
            vecs++;
            if ({o_err, o_ready, o_busy} !== 3'b100) begin
                errs++; $display("FAIL len_%h_err: err/ready/busy got %b expected 100", lens[k], {o_err, o_ready, o_busy});
            end
            repeat (5) @(negedge i_clk);
            #1;
            vecs++;
            if (wa.size() != 0) begin errs++; $display("FAIL len_%h_writes: got %0d expected 0", lens[k], wa.size()); end
        end
    endtask

    task automatic test_random_valid;
        int dc0;
        logic [7:0] bytes [5];
        logic [7:0] exp_d;
        bytes[0] = 8'h03; bytes[1] = 8'h51; bytes[2] = 8'hE0; bytes[3] = 8'hF0; bytes[4] = 8'h24;
        clear_log();
        dc0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            if (i == 2) begin
                i_start = 1'b1;
                @(negedge i_clk);
                i_start = 1'b0;
            end
            send(bytes[i]);
        end
        wait_idle();
        vecs++;
        if (wa.size() != 16) begin errs++; $display("FAIL rand_count: got %0d writes expected 16", wa.size()); end
        for (int i = 0; i < 16; i++) begin
            exp_d = (i == 0) ? 8'h51 : (i == 1) ? 8'hE0 : 8'hF0;
            vecs++;
            if (i >= wa.size() || wa[i] !== 4'(i) || wd[i] !== exp_d) begin
                errs++; $display("FAIL rand_write[%0d]: got %h/%h expected %h/%h", i,
                                 (i < wa.size()) ? wa[i] : 4'hx, (i < wd.size()) ? wd[i] : 8'hxx, 4'(i), exp_d);
            end
        end
        vecs++;
        if (done_cnt - dc0 != 1 || o_cpu_rst_n !== 1'b1) begin
            errs++; $display("FAIL rand_done: done %0d rst_n %b expected 1 1", done_cnt - dc0, o_cpu_rst_n);
        end
    endtask

    task automatic test_mid_reset;
        logic [19:0] outs;
        clear_log();
        pulse_start();
        send(8'h03); send(8'h51); send(8'hE0);
        #2;
        i_rst = 1'b1;
        #1;
        outs = {o_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_busy, o_done, o_err};
        vecs++;
        if (outs !== 20'h0) begin errs++; $display("FAIL midrst_async: got %h expected 00000", outs); end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_valid = 1'b1;
        i_data = 8'hF0;
        repeat (5) @(negedge i_clk);
        #1;
        vecs++;
        if ({o_ready, o_busy, o_cpu_rst_n, o_we} !== 4'b0000) begin
            errs++; $display("FAIL midrst_idle: ready/busy/rst_n/we got %b expected 0000", {o_ready, o_busy, o_cpu_rst_n, o_we});
        end
        vecs++;
        if (wa.size() != 2) begin errs++; $display("FAIL midrst_writes: got %0d expected 2", wa.size()); end
        i_valid = 1'b0;
    endtask

    initial begin
        i_clk = 1'b0; i_rst = 1'b1; i_start = 1'b0; i_data = 8'h00; i_valid = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_bad_csum();
        test_bad_len();
        test_random_valid();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
